// File: rtl/board_cell_memory_if.sv
// Board storage bus: control-side writes/clears and reader-side reads.
// The master drives requests, the slave (storage) returns responses.
interface board_cell_memory_if #(
  parameter int X_W    = 4,
  parameter int Y_W    = 4,
  parameter int CELL_W = 2,
  parameter int CNT_W  = 9
);
  logic              clear_req;
  logic              busy;
  logic              wr_en;
  logic [X_W-1:0]    wr_x;
  logic [Y_W-1:0]    wr_y;
  logic [CELL_W-1:0] wr_data;
  logic              wr_ack;
  logic              wr_err;
  logic              rd_en;
  logic [X_W-1:0]    rd_x;
  logic [Y_W-1:0]    rd_y;
  logic [CELL_W-1:0] rd_data;
  logic              rd_valid;
  logic [CNT_W-1:0]  occupied;
  logic              full;

  modport master (
    output clear_req, wr_en, wr_x, wr_y, wr_data,
    output rd_en, rd_x, rd_y,
    input  busy, wr_ack, wr_err, rd_data, rd_valid,
    input  occupied, full
  );

  modport slave (
    input  clear_req, wr_en, wr_x, wr_y, wr_data,
    input  rd_en, rd_x, rd_y,
    output busy, wr_ack, wr_err, rd_data, rd_valid,
    output occupied, full
  );
endinterface

// File: rtl/board_cell_memory.sv
// GoBang board storage: checked stone writes, registered reads,
// row-per-cycle clear sequencer and occupied-point counter.
module board_cell_memory #(
  parameter int ROWS   = 16,
  parameter int COLS   = 16,
  parameter int X_W    = 4,
  parameter int Y_W    = 4,
  parameter int CELL_W = 2,
  parameter int CNT_W  = $clog2(ROWS*COLS+1)
) (
  input  logic               clock,
  input  logic               resetn,
  board_cell_memory_if.slave bus
);

  localparam int RA_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CA_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CELLS = ROWS * COLS;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [RA_W-1:0]   ptr;
  logic [CELL_W-1:0] mem [ROWS][COLS];

  logic [RA_W-1:0]   wr_r, rd_r;
  logic [CA_W-1:0]   wr_c, rd_c;
  logic              wr_in, rd_in, wr_ok;
  logic [CELL_W-1:0] wr_cell;
  logic [CNT_W-1:0]  occ_nxt;

  always_comb begin
    wr_r    = bus.wr_x[RA_W-1:0];
    wr_c    = bus.wr_y[CA_W-1:0];
    rd_r    = bus.rd_x[RA_W-1:0];
    rd_c    = bus.rd_y[CA_W-1:0];
    wr_in   = (32'(bus.wr_x) < ROWS) && (32'(bus.wr_y) < COLS);
    rd_in   = (32'(bus.rd_x) < ROWS) && (32'(bus.rd_y) < COLS);
    wr_cell = mem[wr_r][wr_c];
    // Low index bits only address the array once the range check passes
    wr_ok   = bus.wr_en && (state == IDLE) && wr_in &&
              (bus.wr_data != '0) && (wr_cell == '0);
    occ_nxt = bus.occupied + CNT_W'(wr_ok);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      ptr          <= '0;
      bus.busy     <= 1'b0;
      bus.wr_ack   <= 1'b0;
      bus.wr_err   <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
      bus.occupied <= '0;
      bus.full     <= 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          mem[r][c] <= '0;
    end else begin
      bus.wr_ack   <= wr_ok;
      bus.wr_err   <= bus.wr_en && !wr_ok;
      bus.rd_valid <= 1'b0;
      if (wr_ok)
        mem[wr_r][wr_c] <= bus.wr_data;
      unique case (state)
        IDLE: begin
          bus.occupied <= occ_nxt;
          bus.full     <= (occ_nxt == CNT_W'(CELLS));
          if (bus.rd_en) begin
            bus.rd_valid <= 1'b1;
            bus.rd_data  <= rd_in ? mem[rd_r][rd_c] : '0;
          end
          if (bus.clear_req) begin
            state    <= CLEAR;
            ptr      <= '0;
            bus.busy <= 1'b1;
          end
        end
        CLEAR: begin
          for (int c = 0; c < COLS; c++)
            mem[ptr][c] <= '0;
          ptr <= ptr + RA_W'(1);
          if (ptr == RA_W'(ROWS-1)) begin
            state        <= IDLE;
            bus.busy     <= 1'b0;
            bus.occupied <= '0;
            bus.full     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_cell_memory.sv
// Scoreboard bench for board_cell_memory against a board-array model.
// Wide coordinates (5 bits) let out-of-range accesses be exercised.
module tb_board_cell_memory;

  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int XW   = 5;
  localparam int YW   = 5;
  localparam int CW   = 2;
  localparam int NW   = 9;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  board_cell_memory_if #(.X_W(XW), .Y_W(YW), .CELL_W(CW), .CNT_W(NW)) bus ();

  board_cell_memory #(
    .ROWS(ROWS), .COLS(COLS), .X_W(XW), .Y_W(YW), .CELL_W(CW), .CNT_W(NW)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  typedef struct {
    int busy;
    int occ;
    int full;
    int wr;   // -1 no response, 0 reject, 1 accept
    int rd;   // -1 no valid, else value
    int rdd;  // rd_data expected (held)
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   board [ROWS][COLS];
  int   clr_left = 0;
  int   last_rd  = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int occ_count();
    int n = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (board[r][c] != 0) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        board[r][c] = 0;
    clr_left = 0;
    last_rd  = 0;
  endtask

  task automatic step(input bit we, input int wx, input int wy, input int wd,
                      input bit re, input int rx, input int ry, input bit clr);
    exp_t e;
    bit   bsy;
    bit   ok;
    @(negedge clock);
    bus.wr_en     = we;
    bus.wr_x      = XW'(wx);
    bus.wr_y      = YW'(wy);
    bus.wr_data   = CW'(wd);
    bus.rd_en     = re;
    bus.rd_x      = XW'(rx);
    bus.rd_y      = YW'(ry);
    bus.clear_req = clr;
    bsy  = (clr_left > 0);
    e.wr = -1;
    e.rd = -1;
    if (re && !bsy) begin
      e.rd    = (rx < ROWS && ry < COLS) ? board[rx][ry] : 0;
      last_rd = e.rd;
    end
    if (we) begin
      ok = !bsy && wx < ROWS && wy < COLS && wd != 0 && board[wx][wy] == 0;
      e.wr = ok ? 1 : 0;
      if (ok) board[wx][wy] = wd;
    end
    if (bsy) begin
      clr_left--;
      if (clr_left == 0)
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            board[r][c] = 0;
    end else if (clr) begin
      clr_left = ROWS;
    end
    e.busy = (clr_left > 0) ? 1 : 0;
    e.occ  = occ_count();
    e.full = (e.occ == ROWS*COLS) ? 1 : 0;
    e.rdd  = last_rd;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic quiet_inputs();
    bus.wr_en = 0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_data = '0;
    bus.rd_en = 0; bus.rd_x = '0; bus.rd_y = '0; bus.clear_req = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},     int'(bus.busy), 0);
    check({tag, "_occupied"}, int'(bus.occupied), 0);
    check({tag, "_full"},     int'(bus.full), 0);
    check({tag, "_rd_valid"}, int'(bus.rd_valid), 0);
    check({tag, "_rd_data"},  int'(bus.rd_data), 0);
    check({tag, "_wr_ack"},   int'(bus.wr_ack), 0);
  endtask

  task automatic read_all();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        step(0, 0, 0, 0, 1, r, c, 0);
  endtask

  // Monitor: one expectation per driven cycle, checked after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (resetn && q.size() > 0) begin
        e = q.pop_front();
        check("busy",     int'(bus.busy), e.busy);
        check("occupied", int'(bus.occupied), e.occ);
        check("full",     int'(bus.full), e.full);
        check("wr_ack",   int'(bus.wr_ack), (e.wr == 1) ? 1 : 0);
        check("wr_err",   int'(bus.wr_err), (e.wr == 0) ? 1 : 0);
        check("rd_valid", int'(bus.rd_valid), (e.rd >= 0) ? 1 : 0);
        check("rd_data",  int'(bus.rd_data), e.rdd);
      end
    end
  end

  initial begin
    quiet_inputs();
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clock);
    resetn = 1'b1;

    // Directed cases
    step(0, 0, 0, 0, 1, 3, 5, 0);
    step(1, 3, 5, 1, 0, 0, 0, 0);
    step(1, 3, 5, 2, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 3, 5, 0);
    step(1, 4, 4, 0, 0, 0, 0, 0);
    step(1, 16, 0, 1, 0, 0, 0, 0);
    step(1, 0, 16, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 15, 16, 0);
    step(1, 7, 7, 2, 1, 7, 7, 0);
    step(0, 0, 0, 0, 1, 7, 7, 0);
    step(1, 9, 9, 3, 0, 0, 0, 0);
    step(1, 9, 9, 1, 1, 9, 9, 0);
    idle(1);

    // Randomised mix including occasional clears
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), $urandom_range(0, 17), $urandom_range(0, 17),
           $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 17),
           $urandom_range(0, 17), ($urandom_range(0, 49) == 0));

    // Ensure an empty board, then fill completely
    step(0, 0, 0, 0, 0, 0, 0, 1);
    idle(ROWS + 1);
    step(1, 2, 2, 1, 0, 0, 0, 1);
    idle(ROWS + 1);
    for (int i = 0; i < ROWS*COLS; i++)
      step(1, i / COLS, i % COLS, (i % 2) ? 2 : 1,
           $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15), 0);
    step(1, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < ROWS; i++)
      step(1, $urandom_range(0, 15), $urandom_range(0, 15), 1,
           1, $urandom_range(0, 15), $urandom_range(0, 15), 1);
    read_all();

    // Reset in the middle of a clear
    step(1, 0, 0, 1, 0, 0, 0, 0);
    step(1, 5, 6, 2, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    idle(5);
    @(negedge clock);
    quiet_inputs();
    resetn = 1'b0;
    #1;
    check_reset_outputs("midclr");
    model_reset();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    step(1, 0, 0, 1, 0, 0, 0, 0);
    read_all();
    idle(2);

    @(posedge clock);
    #2;
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
